instr_queue: RTL and testbench
==============================

Name: instr_queue

Overview:
- Decoupling buffer directly downstream of instruction fetch and upstream of decode/dual-issue.
- Captures fetched instruction pairs with their PC in a small circular FIFO.
- Presents the oldest pair to the issue logic. Supports full issue, partial issue (first slot only), branch flush and stop.
- Absorbs fetch/issue rate mismatch so dependency stalls in issue need not back-propagate combinationally into fetch.

Parameters:
- WORD, 32, instruction and PC width in bits
- DEPTH, 4, number of pair entries; power of two, minimum 2
- LNOP, 32'h00200000, encoding substituted into a slot that has already issued

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears queue immediately
- in_valid  input  1  fetch presents a pair this cycle
- in_instr1  input  WORD  first (older) instruction of the pair
- in_instr2  input  WORD  second instruction of the pair
- in_pc  input  WORD  PC of in_instr1
- in_ready  output  1  queue can accept a pair this cycle
- flush  input  1  branch taken; discard all contents
- stop_and_signal  input  1  processor halted; freeze queue
- out_valid  output  1  head pair available
- out_instr1  output  WORD  head first slot (LNOP if already issued)
- out_instr2  output  WORD  head second slot
- out_pc  output  WORD  PC of head pair
- issue_both  input  1  both head slots issued; pop head
- issue_first  input  1  only first slot issued; keep head, retire slot 1
- count  output  $clog2(DEPTH)+1  number of valid entries

Behaviour:
- Reset (async): count=0, wr_ptr=rd_ptr=0, out_valid=0, in_ready=1. All per-entry "slot1 issued" flags cleared.
- Storage: DEPTH entries of {instr1, instr2, pc, s1_done}, circular. Pointers wrap modulo DEPTH.
- in_ready = (count < DEPTH) && !stop_and_signal. Purely registered-state driven; no path from issue_* to in_ready.
- Enqueue when in_valid && in_ready && !flush:
  - write entry at wr_ptr with s1_done=0, then wr_ptr+1.
  - in_valid while !in_ready: pair dropped; fetch must hold it.
- out_valid = (count != 0).
- out_instr1 = head.s1_done ? LNOP : head.instr1. out_instr2/out_pc come from the head entry.
- Outputs are combinational from head registers, giving 1-cycle latency from enqueue to out_valid.
- issue_both && out_valid && !stop_and_signal: rd_ptr+1.
- issue_first && !issue_both && out_valid && !stop_and_signal:
  - set head.s1_done=1. No pop, no pointer or count change.
  - Next cycle out_instr1=LNOP and out_instr2 is unchanged.
- issue_both and issue_first together: treated as issue_both.
- Any issue_* with out_valid=0: ignored.
- Simultaneous enqueue and pop: count unchanged, both pointers advance.
- Full queue: a pop in the same cycle does NOT allow an enqueue (in_ready already 0).
- flush (highest priority after reset):
  - next edge count=0, rd_ptr=wr_ptr=0, all s1_done cleared.
  - Same-cycle in_valid and issue_* are ignored.
- stop_and_signal=1 (flush=0):
  - no enqueue, no pop, no s1_done update.
  - Contents and outputs held.
  - out_valid still reflects count.
- Reset asserted mid-operation: queue empties asynchronously. Pairs in flight are lost; fetch restarts from its own reset PC.

Optional Feature:
- Macro: IQ_BYPASS_EN.
- Defined:
  - when count==0 && in_valid && !flush && !stop_and_signal, out_valid=1 and out_* = in_* combinationally (zero-latency).
  - If issue_both is asserted that cycle, the pair is consumed and not written.
  - If issue_first is asserted, the pair is written with s1_done=1.
  - Otherwise it is written normally.
- Undefined: no bypass; minimum latency enqueue->out_valid is one cycle. Bypass adds a combinational path fetch->issue.

Test Plan:
- Reset, enqueue {32'h1111_0000, 32'h2222_0000, pc=0} -> next cycle out_valid=1, out_instr1=32'h1111_0000, out_pc=0, count=1.
- Enqueue 4 pairs (pc 0,8,16,24) with no issue -> count=4, in_ready=0. A 5th in_valid is dropped. issue_both -> out_pc=8, count=3, in_ready=1.
- Head pc=0, issue_first -> out_instr1=32'h00200000, out_instr2 unchanged, count unchanged. Then issue_both -> head pc=8.
- Queue holding 3 entries, flush with in_valid=1 and issue_both=1 -> next cycle count=0, out_valid=0. Subsequent enqueue appears at head.
- stop_and_signal=1 with issue_both and in_valid asserted for 3 cycles -> count, out_pc and out_instr* unchanged, in_ready=0.
- Assert reset asynchronously between edges with count=2 -> out_valid=0 and count=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/instr_queue.sv
// Instruction queue between fetch and dual-issue: circular FIFO of instruction pairs.
// Optional zero-latency fetch->issue bypass when empty: define IQ_BYPASS_EN.
module instr_queue #(
    parameter int              WORD  = 32,
    parameter int              DEPTH = 4,
    parameter logic [WORD-1:0] LNOP  = 'h00200000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [WORD-1:0]          in_instr1,
    input  logic [WORD-1:0]          in_instr2,
    input  logic [WORD-1:0]          in_pc,
    output logic                     in_ready,
    input  logic                     flush,
    input  logic                     stop_and_signal,
    output logic                     out_valid,
    output logic [WORD-1:0]          out_instr1,
    output logic [WORD-1:0]          out_instr2,
    output logic [WORD-1:0]          out_pc,
    input  logic                     issue_both,
    input  logic                     issue_first,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   FULL = (PW+1)'(DEPTH);
    localparam logic [PW:0]   C1   = (PW+1)'(1);
    localparam logic [PW-1:0] P1   = PW'(1);

    logic [WORD-1:0]  instr1_q [DEPTH];
    logic [WORD-1:0]  instr1_d [DEPTH];
    logic [WORD-1:0]  instr2_q [DEPTH];
    logic [WORD-1:0]  instr2_d [DEPTH];
    logic [WORD-1:0]  pc_q     [DEPTH];
    logic [WORD-1:0]  pc_d     [DEPTH];
    logic [DEPTH-1:0] s1_done_q, s1_done_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;

    logic byp;
    logic do_enq;
    logic do_pop;
    logic do_first;

`ifdef IQ_BYPASS_EN
    assign byp = (count_q == '0) && in_valid && !flush && !stop_and_signal;
`else
    assign byp = 1'b0;
`endif

    // Head presentation; bypass forwards the incoming pair while empty
    always_comb begin
        in_ready   = (count_q < FULL) && !stop_and_signal;
        out_valid  = (count_q != '0) || byp;
        out_instr1 = s1_done_q[rd_ptr_q] ? LNOP : instr1_q[rd_ptr_q];
        out_instr2 = instr2_q[rd_ptr_q];
        out_pc     = pc_q[rd_ptr_q];
        if (byp) begin
            out_instr1 = in_instr1;
            out_instr2 = in_instr2;
            out_pc     = in_pc;
        end
        count = count_q;
    end

    // Qualified events; a bypassed pair issued in full is never stored
    always_comb begin
        do_enq   = in_valid && in_ready && !flush && !(byp && issue_both);
        do_pop   = issue_both && out_valid && !stop_and_signal
                   && !flush && !byp;
        do_first = issue_first && !issue_both && out_valid
                   && !stop_and_signal && !flush;
    end

    // Next-state for storage, pointers and occupancy
    always_comb begin
        instr1_d  = instr1_q;
        instr2_d  = instr2_q;
        pc_d      = pc_q;
        s1_done_d = s1_done_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (flush) begin
            s1_done_d = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
        end else begin
            if (do_enq) begin
                instr1_d[wr_ptr_q]  = in_instr1;
                instr2_d[wr_ptr_q]  = in_instr2;
                pc_d[wr_ptr_q]      = in_pc;
                s1_done_d[wr_ptr_q] = 1'b0;
                wr_ptr_d            = wr_ptr_q + P1;
            end
            // when bypassing, rd_ptr equals wr_ptr so this marks the new entry
            if (do_first) begin
                s1_done_d[rd_ptr_q] = 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + P1;
            end
            unique case ({do_enq, do_pop})
                2'b10:   count_d = count_q + C1;
                2'b01:   count_d = count_q - C1;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr1_q[i] <= '0;
                instr2_q[i] <= '0;
                pc_q[i]     <= '0;
            end
            s1_done_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            instr1_q  <= instr1_d;
            instr2_q  <= instr2_d;
            pc_q      <= pc_d;
            s1_done_q <= s1_done_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue (default build, DEPTH=4).
// Directed vector table, random scoreboard phase, async reset sequence.
module tb_instr_queue;

    localparam logic [31:0] LNOP = 32'h00200000;
    localparam logic [31:0] B1   = 32'h11110000;
    localparam logic [31:0] B2   = 32'h22220000;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_instr1, in_instr2, in_pc;
    logic        in_ready;
    logic        flush, stop_and_signal;
    logic        out_valid;
    logic [31:0] out_instr1, out_instr2, out_pc;
    logic        issue_both, issue_first;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    instr_queue dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_instr1(in_instr1),
        .in_instr2(in_instr2), .in_pc(in_pc),
        .in_ready(in_ready), .flush(flush),
        .stop_and_signal(stop_and_signal),
        .out_valid(out_valid), .out_instr1(out_instr1),
        .out_instr2(out_instr2), .out_pc(out_pc),
        .issue_both(issue_both), .issue_first(issue_first),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic        fl, st, ib, if1;
        logic        ev;
        logic [31:0] ei1, epc;
        int          ecnt;
        logic        erdy;
    } vec_t;

    typedef struct {
        logic [31:0] i1, i2, pc;
        logic        s1;
    } ent_t;

    vec_t vecs[24];
    ent_t sb[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic [31:0] pc,
                                input logic fl, input logic st,
                                input logic ib, input logic if1,
                                input logic ev, input logic [31:0] ei1,
                                input logic [31:0] epc, input int ecnt,
                                input logic erdy);
        vec_t r;
        r.v = v; r.pc = pc; r.fl = fl; r.st = st;
        r.ib = ib; r.if1 = if1; r.ev = ev; r.ei1 = ei1;
        r.epc = epc; r.ecnt = ecnt; r.erdy = erdy;
        return r;
    endfunction

    task automatic idle();
        in_valid = 0; in_instr1 = 0; in_instr2 = 0; in_pc = 0;
        flush = 0; stop_and_signal = 0;
        issue_both = 0; issue_first = 0;
    endtask

    initial begin
        reset = 1;
        idle();
        // v  pc    fl st ib if1  ev  ei1         epc  cnt rdy
        vecs[0]  = mk(1, 'h00, 0,0,0,0, 1, B1+'h00,  'h00, 1, 1);
        vecs[1]  = mk(1, 'h08, 0,0,0,0, 1, B1+'h00,  'h00, 2, 1);
        vecs[2]  = mk(1, 'h10, 0,0,0,0, 1, B1+'h00,  'h00, 3, 1);
        vecs[3]  = mk(1, 'h18, 0,0,0,0, 1, B1+'h00,  'h00, 4, 0);
        vecs[4]  = mk(1, 'h20, 0,0,0,0, 1, B1+'h00,  'h00, 4, 0);
        vecs[5]  = mk(0, 'h00, 0,0,0,1, 1, LNOP,     'h00, 4, 0);
        vecs[6]  = mk(0, 'h00, 0,0,1,0, 1, B1+'h08,  'h08, 3, 1);
        vecs[7]  = mk(1, 'h20, 0,0,1,0, 1, B1+'h10,  'h10, 3, 1);
        vecs[8]  = mk(1, 'h28, 0,0,0,0, 1, B1+'h10,  'h10, 4, 0);
        vecs[9]  = mk(1, 'h30, 0,0,1,0, 1, B1+'h18,  'h18, 3, 1);
        vecs[10] = mk(1, 'h30, 0,1,1,0, 1, B1+'h18,  'h18, 3, 0);
        vecs[11] = mk(1, 'h30, 0,1,1,0, 1, B1+'h18,  'h18, 3, 0);
        vecs[12] = mk(1, 'h30, 0,1,1,0, 1, B1+'h18,  'h18, 3, 0);
        vecs[13] = mk(0, 'h00, 0,1,0,1, 1, B1+'h18,  'h18, 3, 0);
        vecs[14] = mk(1, 'h38, 1,0,1,0, 0, 0,        0,    0, 1);
        vecs[15] = mk(1, 'h40, 0,0,0,0, 1, B1+'h40,  'h40, 1, 1);
        vecs[16] = mk(0, 'h00, 0,0,1,0, 0, 0,        0,    0, 1);
        vecs[17] = mk(0, 'h00, 0,0,1,0, 0, 0,        0,    0, 1);
        vecs[18] = mk(0, 'h00, 0,0,0,1, 0, 0,        0,    0, 1);
        vecs[19] = mk(1, 'h48, 0,0,0,0, 1, B1+'h48,  'h48, 1, 1);
        vecs[20] = mk(1, 'h50, 0,0,1,1, 1, B1+'h50,  'h50, 1, 1);
        vecs[21] = mk(0, 'h00, 0,0,0,1, 1, LNOP,     'h50, 1, 1);
        vecs[22] = mk(0, 'h00, 1,0,0,0, 0, 0,        0,    0, 1);
        vecs[23] = mk(0, 'h00, 0,1,0,0, 0, 0,        0,    0, 0);

        repeat (2) @(posedge clk);
        #1 reset = 0;
        #1;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_ready", 32'(in_ready), 1);

        // directed table
        for (int k = 0; k < 24; k++) begin
            in_valid        = vecs[k].v;
            in_pc           = vecs[k].pc;
            in_instr1       = B1 + vecs[k].pc;
            in_instr2       = B2 + vecs[k].pc;
            flush           = vecs[k].fl;
            stop_and_signal = vecs[k].st;
            issue_both      = vecs[k].ib;
            issue_first     = vecs[k].if1;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", k), 32'(out_valid), 32'(vecs[k].ev));
            chk($sformatf("v%0d_count", k), 32'(count), 32'(vecs[k].ecnt));
            chk($sformatf("v%0d_ready", k), 32'(in_ready), 32'(vecs[k].erdy));
            if (vecs[k].ev) begin
                chk($sformatf("v%0d_i1", k), out_instr1, vecs[k].ei1);
                chk($sformatf("v%0d_i2", k), out_instr2, B2 + vecs[k].epc);
                chk($sformatf("v%0d_pc", k), out_pc, vecs[k].epc);
            end
        end
        idle();
        @(posedge clk);
        #1;

        // random traffic against a scoreboard
        sb.delete();
        for (int c = 0; c < 400; c++) begin
            ent_t e;
            logic acc, pop, first;
            in_valid        = ($urandom_range(0, 9) < 7);
            in_instr1       = $urandom;
            in_instr2       = $urandom;
            in_pc           = $urandom;
            issue_both      = ($urandom_range(0, 9) < 4);
            issue_first     = ($urandom_range(0, 9) < 2);
            flush           = ($urandom_range(0, 99) < 3);
            stop_and_signal = ($urandom_range(0, 9) < 1);
            #1;
            chk("sb_valid", 32'(out_valid), 32'(sb.size() != 0));
            chk("sb_count", 32'(count), 32'(sb.size()));
            chk("sb_ready", 32'(in_ready),
                32'((sb.size() < 4) && !stop_and_signal));
            if (sb.size() != 0) begin
                chk("sb_i1", out_instr1, sb[0].s1 ? LNOP : sb[0].i1);
                chk("sb_i2", out_instr2, sb[0].i2);
                chk("sb_pc", out_pc, sb[0].pc);
            end
            if (flush) begin
                sb.delete();
            end else if (!stop_and_signal) begin
                acc   = in_valid && (sb.size() < 4);
                pop   = issue_both && (sb.size() != 0);
                first = issue_first && !issue_both && (sb.size() != 0);
                if (first) sb[0].s1 = 1'b1;
                if (pop) void'(sb.pop_front());
                if (acc) begin
                    e.i1 = in_instr1; e.i2 = in_instr2;
                    e.pc = in_pc; e.s1 = 1'b0;
                    sb.push_back(e);
                end
            end
            @(posedge clk);
            #1;
        end

        // async reset mid-operation with two entries
        idle();
        @(posedge clk); #1;
        flush = 1;
        @(posedge clk); #1;
        flush = 0;
        in_valid = 1; in_pc = 'h100;
        in_instr1 = B1; in_instr2 = B2;
        @(posedge clk); #1;
        in_pc = 'h108;
        @(posedge clk); #1;
        idle();
        chk("pre_rst_count", 32'(count), 2);
        #2 reset = 1;
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_count", 32'(count), 0);
        chk("arst_ready", 32'(in_ready), 1);
        @(posedge clk); #1;
        reset = 0;
        @(posedge clk); #1;
        chk("post_rst_count", 32'(count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
